// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants for the seven-segment scanner.
// Holds the active-high hex segment patterns (bit0=a ... bit6=g), the
// blank pattern and a small lookup helper used by the decoder.
package seven_seg_pkg;

    // Active-high segment patterns, written g..a from left to right.
    localparam logic [6:0] SEG_HEX_0 = 7'b0111111;
    localparam logic [6:0] SEG_HEX_1 = 7'b0000110;
    localparam logic [6:0] SEG_HEX_2 = 7'b1011011;
    localparam logic [6:0] SEG_HEX_3 = 7'b1001111;
    localparam logic [6:0] SEG_HEX_4 = 7'b1100110;
    localparam logic [6:0] SEG_HEX_5 = 7'b1101101;
    localparam logic [6:0] SEG_HEX_6 = 7'b1111101;
    localparam logic [6:0] SEG_HEX_7 = 7'b0000111;
    localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [6:0] SEG_HEX_9 = 7'b1101111;
    localparam logic [6:0] SEG_HEX_A = 7'b1110111;
    localparam logic [6:0] SEG_HEX_B = 7'b1111100;
    localparam logic [6:0] SEG_HEX_C = 7'b0111001;
    localparam logic [6:0] SEG_HEX_D = 7'b1011110;
    localparam logic [6:0] SEG_HEX_E = 7'b1111001;
    localparam logic [6:0] SEG_HEX_F = 7'b1110001;

    // All segments dark (active-high sense).
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Table indexed directly by the nibble value: element [n] is digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
        SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
        SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
        SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
    };

    // Nibble to active-high segment pattern.
    function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: purely combinational hex nibble to active-high
// seven-segment pattern (bit0=a ... bit6=g). Polarity is handled by the
// caller at its output registers.
module seg7_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    // Table lookup; every nibble value has a defined pattern.
    always_comb begin
        segments = seg_lookup(nibble);
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for NUM_DIGITS seven-segment
// digits. A prescaler produces a tick every CLK_DIV cycles; each tick moves
// the scan to the next digit. New data is staged in a pending register and
// only copied to the display register when the scan wraps to digit 0, so a
// frame never shows a mix of old and new digits.
//
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank every digit
// above the highest nonzero digit (digit 0 is always shown).
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned CLK_DIV          = 100000,
    parameter bit          ANODE_ACTIVE_LOW = 1'b0,
    parameter bit          SEG_ACTIVE_LOW   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    output logic                    busy,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp_out
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Inactive levels of the output pins for the selected polarity.
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [6:0]            CATH_OFF  = {7{SEG_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] presc_reg;
    logic [IDX_W-1:0] index_reg;
    logic             tick;
    logic             wrap;
    logic             frame_done_reg;

    // With CLK_DIV=1 the counter is pinned at 0 and tick is always high.
    assign tick = (presc_reg == PRE_LAST);
    assign wrap = tick && (index_reg == IDX_LAST);

    // Prescaler: count 0..CLK_DIV-1, restart after the tick cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRE_W'(1);
        end
    end

    // Digit index: advance on tick, wrap from the last digit back to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_reg <= '0;
        end else if (wrap) begin
            index_reg <= '0;
        end else if (tick) begin
            index_reg <= index_reg + IDX_W'(1);
        end
    end

    // Frame pulse: high for the one cycle following the wrap edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= wrap;
        end
    end

    assign frame_done = frame_done_reg;

    // ------------------------------------------------------------------
    // Pending / display data
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] pend_value_reg;
    logic [NUM_DIGITS-1:0]   pend_dp_reg;
    logic [4*NUM_DIGITS-1:0] disp_value_reg;
    logic [NUM_DIGITS-1:0]   disp_dp_reg;
    logic                    busy_reg;

    // Pending register: every load overwrites it, so the last load wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_value_reg <= '0;
            pend_dp_reg    <= '0;
        end else if (load) begin
            pend_value_reg <= value;
            pend_dp_reg    <= dp;
        end
    end

    // Display register: updated only at a frame wrap. A load landing on the
    // wrap edge bypasses the pending stage so it is not held a whole frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_value_reg <= '0;
            disp_dp_reg    <= '0;
        end else if (wrap) begin
            if (load) begin
                disp_value_reg <= value;
                disp_dp_reg    <= dp;
            end else if (busy_reg) begin
                disp_value_reg <= pend_value_reg;
                disp_dp_reg    <= pend_dp_reg;
            end
        end
    end

    // Busy: set by a load, cleared by the wrap that consumes the data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg <= 1'b0;
        end else if (wrap) begin
            busy_reg <= 1'b0;
        end else if (load) begin
            busy_reg <= 1'b1;
        end
    end

    assign busy = busy_reg;

    // ------------------------------------------------------------------
    // Current-digit selection and decode
    // ------------------------------------------------------------------
    logic [3:0]            digit_nibble [NUM_DIGITS];
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [6:0]            cur_seg;
    logic [NUM_DIGITS-1:0] anode_onehot;

    genvar gi;

    // Split the display word into per-digit nibbles; digit 0 is the LSBs.
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : gen_nibble
        assign digit_nibble[gi] = disp_value_reg[4*gi +: 4];
    end

    assign cur_nibble   = digit_nibble[index_reg];
    assign cur_dp       = disp_dp_reg[index_reg];
    assign anode_onehot = NUM_DIGITS'(1) << index_reg;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    logic [NUM_DIGITS-1:0] blank_mask;

    assign blank_mask[0] = 1'b0;
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : gen_blank
        assign blank_mask[gi] = (disp_value_reg[4*NUM_DIGITS-1:4*gi] == '0);
    end

    assign cur_blank = blank_mask[index_reg];
`else
    assign cur_blank = 1'b0;
`endif

    seg7_decoder u_decoder (
        .nibble   (cur_nibble),
        .segments (cur_seg)
    );

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] anode_reg;
    logic [6:0]            cathode_reg;
    logic                  dp_out_reg;

    // Register the pins together; polarity is applied only here so all
    // internal logic stays active-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode_reg   <= ANODE_OFF;
            cathode_reg <= CATH_OFF;
            dp_out_reg  <= SEG_ACTIVE_LOW;
        end else begin
            anode_reg   <= anode_onehot ^ ANODE_OFF;
            cathode_reg <= (cur_blank ? SEG_BLANK : cur_seg) ^ CATH_OFF;
            dp_out_reg  <= (cur_dp & ~cur_blank) ^ SEG_ACTIVE_LOW;
        end
    end

    assign anode   = anode_reg;
    assign cathode = cathode_reg;
    assign dp_out  = dp_out_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed, table-driven bench for seven_seg_scanner
// (NUM_DIGITS=4, CLK_DIV=4) plus a second instance with CLK_DIV=1 and
// active-low anodes. Expectations follow SEG_LEADING_ZERO_BLANK_EN.
module tb_seven_seg_scanner;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    // Reference patterns, active-high, g..a.
    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1111101;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1101111;
    localparam logic [6:0] SA = 7'b1110111;
    localparam logic [6:0] SB = 7'b1111100;
    localparam logic [6:0] SC = 7'b0111001;
    localparam logic [6:0] SD = 7'b1011110;
    localparam logic [6:0] SE = 7'b1111001;
    localparam logic [6:0] SF = 7'b1110001;
    localparam logic [6:0] LZ = BLANK_EN ? 7'b0000000 : S0;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        busy;
    logic        frame_done;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp_out;

    logic        fast_busy;
    logic        fast_frame_done;
    logic [3:0]  fast_anode;
    logic [6:0]  fast_cathode;
    logic        fast_dp_out;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp_in;
        logic [3:0][6:0] cath;    // [k] = expected cathode of digit k
        logic [3:0]      dp_exp;
    } vec_t;

    vec_t vecs [7];

    seven_seg_scanner #(
        .NUM_DIGITS       (4),
        .CLK_DIV          (4),
        .ANODE_ACTIVE_LOW (1'b0),
        .SEG_ACTIVE_LOW   (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .busy       (busy),
        .frame_done (frame_done),
        .anode      (anode),
        .cathode    (cathode),
        .dp_out     (dp_out)
    );

    seven_seg_scanner #(
        .NUM_DIGITS       (4),
        .CLK_DIV          (1),
        .ANODE_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW   (1'b0)
    ) dut_fast (
        .clk        (clk),
        .rst        (rst),
        .value      (16'h0000),
        .dp         (4'h0),
        .load       (1'b0),
        .busy       (fast_busy),
        .frame_done (fast_frame_done),
        .anode      (fast_anode),
        .cathode    (fast_cathode),
        .dp_out     (fast_dp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pulse load for exactly one rising edge, starting from a negedge.
    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Advance until frame_done is seen at a negedge, bounded.
    task automatic wait_frame();
        int n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("frame_wait", {31'd0, frame_done}, 32'd1);
    endtask

    // Called at the negedge where frame_done is high; checks the next frame.
    task automatic check_frame(input string tag, input logic [3:0][6:0] cath, input logic [3:0] dpx);
        int k;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            k = (c - 1) / 4;
            chk({tag, "_anode"},   {28'd0, anode},      32'(4'b0001 << k));
            chk({tag, "_cathode"}, {25'd0, cathode},    {25'd0, cath[k]});
            chk({tag, "_dp"},      {31'd0, dp_out},     {31'd0, dpx[k]});
            chk({tag, "_frame"},   {31'd0, frame_done}, {31'd0, (c == 16)});
        end
        $display("frame %s checked: %0d vectors, %0d miscompares", tag, vectors, miscompares);
    endtask

    initial begin
        rst   = 1'b0;
        load  = 1'b0;
        value = 16'h0000;
        dp    = 4'h0;

        vecs[0] = '{value: 16'h12AF, dp_in: 4'b0000, cath: {S1, S2, SA, SF}, dp_exp: 4'b0000};
        vecs[1] = '{value: 16'h3333, dp_in: 4'b0101, cath: {S3, S3, S3, S3}, dp_exp: 4'b0101};
        vecs[2] = '{value: 16'h0030, dp_in: 4'b1001, cath: {LZ, LZ, S3, S0},
                    dp_exp: (BLANK_EN ? 4'b0001 : 4'b1001)};
        vecs[3] = '{value: 16'h4567, dp_in: 4'b1111, cath: {S4, S5, S6, S7}, dp_exp: 4'b1111};
        vecs[4] = '{value: 16'h89BC, dp_in: 4'b0010, cath: {S8, S9, SB, SC}, dp_exp: 4'b0010};
        vecs[5] = '{value: 16'hDE00, dp_in: 4'b0100, cath: {SD, SE, S0, S0}, dp_exp: 4'b0100};
        vecs[6] = '{value: 16'h0000, dp_in: 4'b0011, cath: {LZ, LZ, LZ, S0},
                    dp_exp: (BLANK_EN ? 4'b0001 : 4'b0011)};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_anode",      {28'd0, anode},        32'h0);
        chk("rst_cathode",    {25'd0, cathode},      32'h0);
        chk("rst_dp_out",     {31'd0, dp_out},       32'h0);
        chk("rst_busy",       {31'd0, busy},         32'h0);
        chk("rst_frame_done", {31'd0, frame_done},   32'h0);
        chk("rst_fast_anode", {28'd0, fast_anode},   32'hF);
        chk("rst_fast_cath",  {25'd0, fast_cathode}, 32'h0);
        rst = 1'b1;

        // First active output and the CLK_DIV=1 active-low anode rotation
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            chk("fast_anode", {28'd0, fast_anode}, 32'(~(4'b0001 << ((n - 1) % 4)) & 4'hF));
            chk("fast_frame", {31'd0, fast_frame_done}, {31'd0, (n % 4 == 0)});
            if (n == 1) begin
                chk("first_anode",   {28'd0, anode},   32'h1);
                chk("first_cathode", {25'd0, cathode}, {25'd0, S0});
            end
        end

        // Table: load, wait for the wrap, check a whole frame
        for (int i = 0; i < 7; i++) begin
            $display("vector %0d: load value=%h dp=%b", i, vecs[i].value, vecs[i].dp_in);
            do_load(vecs[i].value, vecs[i].dp_in);
            wait_frame();
            check_frame($sformatf("vec%0d", i), vecs[i].cath, vecs[i].dp_exp);
        end

        // Load during digit 2: no tearing, busy held until the wrap
        do_load(16'h12AF, 4'b0000);
        wait_frame();
        repeat (9) @(negedge clk);
        value = 16'h3333;
        dp    = 4'b0000;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        for (int c = 10; c <= 16; c++) begin
            if (c > 10) @(negedge clk);
            chk("tear_anode",   {28'd0, anode},   (c <= 12) ? 32'h4 : 32'h8);
            chk("tear_cathode", {25'd0, cathode}, (c <= 12) ? {25'd0, S2} : {25'd0, S1});
            chk("tear_busy",    {31'd0, busy},    {31'd0, (c <= 15)});
        end
        check_frame("tear_next", {S3, S3, S3, S3}, 4'b0000);

        // Two loads in one frame: last load wins
        repeat (2) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        chk("twice_busy1", {31'd0, busy}, 32'h1);
        repeat (2) @(negedge clk);
        do_load(16'h2222, 4'b0000);
        chk("twice_busy2", {31'd0, busy}, 32'h1);
        wait_frame();
        check_frame("twice", {S2, S2, S2, S2}, 4'b0000);

        // Load coinciding with the wrap tick is applied at that wrap
        repeat (15) @(negedge clk);
        do_load(16'h4567, 4'b1111);
        chk("coin_frame", {31'd0, frame_done}, 32'h1);
        chk("coin_busy",  {31'd0, busy},       32'h0);
        check_frame("coin", vecs[3].cath, 4'b1111);

        // Mid-scan reset discards pending data
        do_load(16'h3333, 4'b1111);
        repeat (5) @(negedge clk);
        chk("mid_busy_before", {31'd0, busy}, 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_anode",   {28'd0, anode},      32'h0);
        chk("mid_rst_cathode", {25'd0, cathode},    32'h0);
        chk("mid_rst_busy",    {31'd0, busy},       32'h0);
        chk("mid_rst_dp",      {31'd0, dp_out},     32'h0);
        chk("mid_rst_frame",   {31'd0, frame_done}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rel_anode",   {28'd0, anode},   32'h1);
        chk("mid_rel_cathode", {25'd0, cathode}, {25'd0, S0});
        chk("mid_rel_busy",    {31'd0, busy},    32'h0);
        wait_frame();
        check_frame("after_rst", vecs[6].cath, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (range 1..8).
REQ-002 Parameter CLK_DIV, default 100000, clk cycles each digit is held (range 1..2^20).
REQ-003 Parameter ANODE_ACTIVE_LOW, default 0; when 1, the anode outputs SHALL be inverted.
REQ-004 Parameter SEG_ACTIVE_LOW, default 0; when 1, the cathode outputs SHALL be inverted.
REQ-005 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 value  input  4*NUM_DIGITS  hex nibbles; digit i is value[4i+3:4i], and digit 0 is the rightmost.
REQ-008 dp  input  NUM_DIGITS  decimal-point request per digit.
REQ-009 load  input  1  one-cycle strobe that captures value and dp.
REQ-010 busy  output  1  high while a captured value awaits the frame boundary.
REQ-011 frame_done  output  1  one-cycle pulse when the scan wraps from the last digit to digit 0.
REQ-012 anode  output  NUM_DIGITS  one-hot digit enable.
REQ-013 cathode  output  7  segments, bit0=a ... bit6=g.
REQ-014 dp_out  output  1  decimal-point segment.

Function
REQ-015 The prescaler SHALL count 0..CLK_DIV-1 and assert an internal tick on CLK_DIV-1, then wrap to 0; when CLK_DIV=1, tick SHALL be asserted every cycle.
REQ-016 The digit index SHALL advance on tick and wrap from NUM_DIGITS-1 to 0; frame_done SHALL pulse in the cycle that wrap occurs.
REQ-017 On load, value and dp SHALL be captured into a pending register and busy SHALL be set in the next cycle.
REQ-018 Pending data SHALL be copied to the display register only on a wrap tick, and busy SHALL clear in the same edge (no tearing within a frame).
REQ-019 If load and a wrap tick coincide, the new load data SHALL be applied at that wrap.
REQ-020 A second load while busy SHALL overwrite the pending data (last load wins).
REQ-021 anode, cathode and dp_out SHALL be registered and reflect the current index one cycle after each index change; anode and cathode SHALL always update in the same edge.
REQ-022 Hex decoding, active-high: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-023 Polarity inversion SHALL be applied only at the output registers.

Reset
REQ-024 While rst is low: prescaler=0, index=0, display and pending registers=0, busy=0, frame_done=0, and anode, cathode and dp_out are all inactive for the selected polarity.
REQ-025 After rst rises, the first active output SHALL be digit 0 showing 0, and a reset mid-frame SHALL discard pending data.

Configuration
REQ-026 With macro SEG_LEADING_ZERO_BLANK_EN defined, every digit above the highest nonzero digit SHALL be blanked (cathode and dp_out inactive, anode still driven), and digit 0 SHALL never be blanked.
REQ-027 Without SEG_LEADING_ZERO_BLANK_EN, all digits SHALL be displayed.

Structure
REQ-028 Package seven_seg_pkg SHALL hold the 16-entry segment pattern constants and the blank pattern.
REQ-029 Sub-module seg7_decoder (4-bit nibble to 7-bit active-high pattern, combinational) SHALL be instantiated once.

Verification (NUM_DIGITS=4, CLK_DIV=4, polarities 0)
REQ-030 Hold rst low mid-scan -> anode=0000, cathode=0000000, busy=0; after release, anode=0001 and cathode=0111111.
REQ-031 Load value=16'h12AF, then wait for the wrap -> anode 0001/0010/0100/1000 each held 4 cycles, with cathode 1110001/1110111/1011011/0000110; frame_done pulses every 16 cycles.
REQ-032 Load 16'h3333 during digit 2 -> busy=1 until the next wrap, digits 2 and 3 keep the old data, and all digits read 1001111 after the wrap.
REQ-033 Load 16'h1111 then 16'h2222 within one frame -> only 1011011 is displayed after the wrap.
REQ-034 With SEG_LEADING_ZERO_BLANK_EN, load 16'h0030 -> digits 3 and 2 show cathode 0000000, digit 1 shows 1001111, digit 0 shows 0111111; without the macro, digits 3 and 2 show 0111111.
REQ-035 With CLK_DIV=1 and ANODE_ACTIVE_LOW=1 -> anode changes every cycle, with the sequence 1110, 1101, 1011, 0111.
